// File: rtl/branch_predictor.sv
// branch_predictor
//   Dynamic branch direction predictor for the 3-stage (IF -> D -> X) core.
//   The branch history table (BHT) holds LINES tag-less 2-bit saturating
//   counters indexed by pc[IDX_BITS+1:2]. Each counter predicts taken when
//   its MSB is set.
//   The IF lookup is combinational. The prediction is carried through D into
//   X in a small {valid, taken} pipeline. In X it is compared with the
//   resolved outcome, and the indexed counter is trained in the same cycle.
//
// Ports
//   clk             core clock, rising edge
//   rst             asynchronous reset, active low
//   stall           holds the prediction pipeline and suppresses BHT updates
//   flush           X-stage redirect; squashes the IF/D predictions
//   if_pc/if_is_br  IF instruction PC / is a conditional branch
//   pred_taken      IF prediction (0 for non-branches)
//   x_pc/x_is_br    X instruction PC / is a conditional branch
//   x_br_taken      resolved branch outcome in X
//   br_pred_correct X prediction matched the outcome (1 for non-branches)
//   br_count        (BP_PERF_CNT_EN only) resolved branches
//   mispred_count   (BP_PERF_CNT_EN only) mispredicted branches
//
// Build option: define BP_PERF_CNT_EN to add the two performance counters.
module branch_predictor #(
  parameter  int unsigned LINES    = 32,
  localparam int unsigned IDX_BITS = $clog2(LINES)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        flush,
  input  logic [31:0] if_pc,
  input  logic        if_is_br,
  output logic        pred_taken,
  input  logic [31:0] x_pc,
  input  logic        x_is_br,
  input  logic        x_br_taken,
  output logic        br_pred_correct
`ifdef BP_PERF_CNT_EN
  ,
  output logic [31:0] br_count,
  output logic [31:0] mispred_count
`endif
);

  typedef struct packed {
    logic valid;
    logic taken;
  } pred_t;

  logic [1:0]          bht_q [LINES];
  logic [1:0]          bht_upd_d;
  logic [IDX_BITS-1:0] if_idx;
  logic [IDX_BITS-1:0] x_idx;
  logic                upd_en;
  pred_t               d_pred_q, d_pred_d;
  pred_t               x_pred_q, x_pred_d;

  // PC bits outside the index field (alias/alignment bits) are not used.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{if_pc[31:IDX_BITS+2], if_pc[1:0],
                            x_pc[31:IDX_BITS+2], x_pc[1:0]};

  assign if_idx = if_pc[IDX_BITS+1:2];
  assign x_idx  = x_pc[IDX_BITS+1:2];

  // The lookup reads the registered table, so a same-cycle update at the
  // same index is seen only from the next cycle on.
  assign pred_taken = if_is_br & bht_q[if_idx][1];

  assign upd_en = x_is_br & ~stall;

  always_comb begin
    bht_upd_d = bht_q[x_idx];
    if (x_br_taken) begin
      if (bht_q[x_idx] != 2'b11) bht_upd_d = bht_q[x_idx] + 2'd1;
    end else begin
      if (bht_q[x_idx] != 2'b00) bht_upd_d = bht_q[x_idx] - 2'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < LINES; i++) bht_q[i] <= 2'b01;
    end else if (upd_en) begin
      bht_q[x_idx] <= bht_upd_d;
    end
  end

  always_comb begin
    d_pred_d = d_pred_q;
    x_pred_d = x_pred_q;
    if (flush) begin
      d_pred_d = '0;
      x_pred_d = '0;
    end else if (!stall) begin
      d_pred_d = '{valid: if_is_br, taken: pred_taken};
      x_pred_d = d_pred_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      d_pred_q <= '0;
      x_pred_q <= '0;
    end else begin
      d_pred_q <= d_pred_d;
      x_pred_q <= x_pred_d;
    end
  end

  // A branch that arrives without a valid prediction counts as predicted
  // not-taken.
  always_comb begin
    br_pred_correct = 1'b1;
    if (x_is_br) begin
      if (x_pred_q.valid) br_pred_correct = (x_pred_q.taken == x_br_taken);
      else                br_pred_correct = ~x_br_taken;
    end
  end

`ifdef BP_PERF_CNT_EN
  logic [31:0] br_count_q, br_count_d;
  logic [31:0] mispred_count_q, mispred_count_d;

  always_comb begin
    br_count_d      = br_count_q;
    mispred_count_d = mispred_count_q;
    if (upd_en) begin
      br_count_d = br_count_q + 32'd1;
      if (!br_pred_correct) mispred_count_d = mispred_count_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      br_count_q      <= '0;
      mispred_count_q <= '0;
    end else begin
      br_count_q      <= br_count_d;
      mispred_count_q <= mispred_count_d;
    end
  end

  assign br_count      = br_count_q;
  assign mispred_count = mispred_count_q;
`endif

endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- Dynamic branch direction predictor for the 3-stage RISC-V core (IF → D → X).
- Lookup in IF: returns pred_taken for the fetched PC.
- The prediction travels with the branch through D into X. In X it is compared against the resolved outcome, and the block drives br_pred_correct to the decode-stage control logic, which uses it for NOP/flush selection.
- The table is updated with the resolved outcome in the same cycle.

Parameters:
- LINES, 32, number of BHT entries; power of two, 4..256.
- IDX_BITS, $clog2(LINES), index width; derived, do not override.

Ports:
- clk  input  1  core clock; all state updates on rising edge.
- rst  input  1  reset, asynchronous, active-low (0 = reset).
- stall  input  1  pipeline stall; freezes the in-flight prediction registers.
- flush  input  1  X-stage redirect (jalr or mispredict); kills the IF and D predictions.
- if_pc  input  32  PC of the instruction in IF.
- if_is_br  input  1  IF instruction is a conditional branch (opcode BRANCH).
- pred_taken  output  1  IF prediction; 0 when if_is_br=0.
- x_pc  input  32  PC of the instruction in X.
- x_is_br  input  1  X instruction is a conditional branch.
- x_br_taken  input  1  resolved branch outcome in X.
- br_pred_correct  output  1  X-stage prediction matched the outcome; 1 when x_is_br=0.

Behaviour:
- BHT: LINES × 2-bit saturating counters.
  - Index = pc[IDX_BITS+1:2]; tag-less.
  - Encoding: 00 strong NT, 01 weak NT, 10 weak T, 11 strong T.
  - Predict taken iff counter[1]=1.
- Lookup is combinational: pred_taken = if_is_br & bht[if_idx][1]. Zero-cycle latency.
- Prediction pipeline: two flops, d_pred and x_pred, each holding {valid, taken}.
  - Normal cycle: d_pred ← {if_is_br, pred_taken}; x_pred ← d_pred.
  - stall=1: d_pred and x_pred hold.
  - flush=1 (has priority over stall): d_pred ← 0 and x_pred ← 0, so the squashed IF/D instructions arrive in X as bubbles.
- br_pred_correct, combinational:
  - x_is_br=0 → 1.
  - x_is_br=1 and x_pred.valid=1 → (x_pred.taken == x_br_taken).
  - x_is_br=1 and x_pred.valid=0 → (x_br_taken == 0); an unpredicted branch is treated as predicted not-taken.
- Update, at the clock edge when x_is_br=1 and stall=0:
  - bht[x_idx] increments if x_br_taken=1, saturating at 11.
  - Otherwise it decrements, saturating at 00.
  - No update when x_is_br=0 or stall=1.
- Same-index collision (read at if_idx and update at x_idx in one cycle): the read returns the pre-update value. No bypass.
- Reset (rst=0, asynchronous):
  - All BHT entries ← 01.
  - d_pred and x_pred ← 0.
  - Outputs settle to pred_taken=0 and br_pred_correct=1 (with x_is_br=0).
  - Reset asserted mid-operation discards in-flight predictions immediately, without waiting for a clock edge.
- Index wrap: PCs differing only above bit IDX_BITS+1 alias to one entry. This is intended.
- pc[1:0] is ignored.

Optional Feature:
- BP_PERF_CNT_EN defined: adds two outputs.
  - br_count [31:0]: increments on each non-stalled cycle with x_is_br=1.
  - mispred_count [31:0]: increments on each non-stalled cycle with x_is_br=1 and br_pred_correct=0.
  - Both reset to 0 on rst=0 and wrap at 2^32.
- Not defined: these ports and registers are absent, and behaviour is otherwise identical.

Test Plan:
- Reset then lookup: rst=0 then released; if_pc=0x100, if_is_br=1 → pred_taken=0 (entry 01). With x_is_br=0 → br_pred_correct=1.
- Training: branch at 0x100 resolved taken twice, via x_is_br=1 and x_br_taken=1 on two non-stalled cycles → entry goes 01→10→11. Next lookup of 0x100 → pred_taken=1. Two not-taken resolutions → 11→10→01, and pred_taken=0.
- Saturation: five taken updates to index 3 → entry stays 11. Five not-taken updates → entry stays 00.
- Mispredict detect: predict taken at IF for 0x100 and advance two cycles. In X drive x_is_br=1, x_br_taken=0 → br_pred_correct=0. Same sequence with x_br_taken=1 → br_pred_correct=1.
- Flush/stall:
  - flush=1 one cycle after a taken prediction; then a branch reaches X with x_br_taken=0 → x_pred.valid=0 and br_pred_correct=1.
  - stall=1 for 3 cycles → x_pred unchanged and no BHT update.
- Collision, plus the optional counters under BP_PERF_CNT_EN:
  - if_pc=x_pc=0x104 with the entry at 01 and x_br_taken=1 → pred_taken=0 that cycle, and 1 the next cycle.
  - 4 branches with 1 mispredict → br_count=4, mispred_count=1.
